bus_fabric: RTL and testbench



---
 rtl/bus_fabric_if.sv | 28 ++
 rtl/bus_fabric.sv | 210 +++++++++++++++++++++
 tb/tb_bus_fabric.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/bus_fabric_if.sv
// Memory bus bundle between the picorv32 native port and the fabric's slave ports.
// The fabric uses the slave modport; the CPU/peripheral side uses master.
interface bus_fabric_if #(
  parameter int N_SLAVES = 4
);
  logic                    m_valid;
  logic [31:0]             m_addr;
  logic [31:0]             m_wdata;
  logic [3:0]              m_wstrb;
  logic [31:0]             m_rdata;
  logic                    m_ready;
  logic [N_SLAVES-1:0]     s_sel;
  logic [31:0]             s_addr;
  logic [31:0]             s_wdata;
  logic [3:0]              s_wstrb;
  logic [N_SLAVES*32-1:0]  s_rdata;
  logic [N_SLAVES-1:0]     s_ready;

  modport master (
    output m_valid, m_addr, m_wdata, m_wstrb, s_rdata, s_ready,
    input  m_rdata, m_ready, s_sel, s_addr, s_wdata, s_wstrb
  );

  modport slave (
    input  m_valid, m_addr, m_wdata, m_wstrb, s_rdata, s_ready,
    output m_rdata, m_ready, s_sel, s_addr, s_wdata, s_wstrb
  );
endinterface

// File: rtl/bus_fabric.sv
// Registered address-decode interconnect with per-transaction timeout and bus-error reporting.
// Optional error interrupt (err_irq / err_irq_clr) enabled by defining BUS_FABRIC_ERR_IRQ_EN.
module bus_fabric #(
  parameter int                     N_SLAVES   = 4,
  parameter logic [N_SLAVES*32-1:0] SLAVE_BASE = {32'h8000_2000, 32'h8000_0008, 32'h8000_0000, 32'h0000_0000},
  parameter logic [N_SLAVES*32-1:0] SLAVE_MASK = {32'hFFFF_F800, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'hFFFF_C000},
  parameter int                     TIMEOUT    = 255,
  parameter logic [31:0]            ERR_RDATA  = 32'hDEAD_BEEF
) (
  input  logic         clk,
  input  logic         reset,
  bus_fabric_if.slave  bus,
  output logic         bus_err,
  output logic [31:0]  err_addr,
  output logic [7:0]   err_count
`ifdef BUS_FABRIC_ERR_IRQ_EN
  ,
  output logic         err_irq,
  input  logic         err_irq_clr
`endif
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  state_e               state_r, state_nxt_s;
  logic [N_SLAVES-1:0]  match_s, dec_sel_s, sel_nxt_s, s_sel_r;
  logic                 hit_s, ready_s, timeout_s, latch_s, resp_err_s, m_ready_nxt_s;
  logic [31:0]          rdata_sel_s, rdata_nxt_s, err_src_s;
  logic [CW-1:0]        cnt_r, cnt_nxt_s;
  logic [31:0]          m_rdata_r, s_addr_r, s_wdata_r, err_addr_r;
  logic [3:0]           s_wstrb_r;
  logic                 m_ready_r, bus_err_r;
  logic [7:0]           err_count_r, err_count_nxt_s;
`ifdef BUS_FABRIC_ERR_IRQ_EN
  logic                 err_irq_r, err_irq_nxt_s;
`endif

  // Address decode; x & -x isolates the lowest matching slot.
  always_comb begin
    match_s = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      match_s[i] = ((bus.m_addr & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32]);
    end
    dec_sel_s = match_s & (~match_s + N_SLAVES'(1));
    hit_s     = |match_s;
  end

  // Selected-slave response; ready on unselected slots is masked off.
  always_comb begin
    rdata_sel_s = 32'd0;
    for (int i = 0; i < N_SLAVES; i++) begin
      rdata_sel_s = rdata_sel_s | (bus.s_rdata[i*32 +: 32] & {32{s_sel_r[i]}});
    end
    ready_s   = |(bus.s_ready & s_sel_r);
    timeout_s = (cnt_r == CNT_LAST);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (bus.m_valid) begin
          state_nxt_s = hit_s ? ST_ACTIVE : ST_RESP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (ready_s || timeout_s) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_ACTIVE;
        end
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: next values of the registered bus outputs. Ready wins over timeout.
  always_comb begin
    sel_nxt_s     = '0;
    m_ready_nxt_s = 1'b0;
    resp_err_s    = 1'b0;
    rdata_nxt_s   = m_rdata_r;
    cnt_nxt_s     = '0;
    latch_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        latch_s = bus.m_valid;
        if (bus.m_valid && hit_s) begin
          sel_nxt_s = dec_sel_s;
        end else if (bus.m_valid) begin
          m_ready_nxt_s = 1'b1;
          resp_err_s    = 1'b1;
          rdata_nxt_s   = ERR_RDATA;
        end else begin
          sel_nxt_s = '0;
        end
      end
      ST_ACTIVE: begin
        if (ready_s) begin
          m_ready_nxt_s = 1'b1;
          rdata_nxt_s   = rdata_sel_s;
        end else if (timeout_s) begin
          m_ready_nxt_s = 1'b1;
          resp_err_s    = 1'b1;
          rdata_nxt_s   = ERR_RDATA;
        end else begin
          sel_nxt_s = s_sel_r;
          cnt_nxt_s = cnt_r + CW'(1);
        end
      end
      ST_RESP: sel_nxt_s = '0;
      default: sel_nxt_s = '0;
    endcase
  end

  // Error bookkeeping; in IDLE the failing address is the one being latched now.
  always_comb begin
    err_src_s       = (state_r == ST_IDLE) ? bus.m_addr : s_addr_r;
    err_count_nxt_s = err_count_r;
    if (resp_err_s) begin
      err_count_nxt_s = (err_count_r == 8'hFF) ? 8'hFF : err_count_r + 8'd1;
`ifdef BUS_FABRIC_ERR_IRQ_EN
    end else if (err_irq_clr) begin
      err_count_nxt_s = 8'd0;
`endif
    end else begin
      err_count_nxt_s = err_count_r;
    end
`ifdef BUS_FABRIC_ERR_IRQ_EN
    if (resp_err_s) begin
      err_irq_nxt_s = 1'b1;
    end else if (err_irq_clr) begin
      err_irq_nxt_s = 1'b0;
    end else begin
      err_irq_nxt_s = err_irq_r;
    end
`endif
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_sel_r     <= '0;
      m_ready_r   <= 1'b0;
      bus_err_r   <= 1'b0;
      m_rdata_r   <= 32'd0;
      s_addr_r    <= 32'd0;
      s_wdata_r   <= 32'd0;
      s_wstrb_r   <= 4'd0;
      err_addr_r  <= 32'd0;
      err_count_r <= 8'd0;
      cnt_r       <= '0;
`ifdef BUS_FABRIC_ERR_IRQ_EN
      err_irq_r   <= 1'b0;
`endif
    end else begin
      s_sel_r     <= sel_nxt_s;
      m_ready_r   <= m_ready_nxt_s;
      bus_err_r   <= resp_err_s;
      m_rdata_r   <= rdata_nxt_s;
      cnt_r       <= cnt_nxt_s;
      err_count_r <= err_count_nxt_s;
      if (latch_s) begin
        s_addr_r  <= bus.m_addr;
        s_wdata_r <= bus.m_wdata;
        s_wstrb_r <= bus.m_wstrb;
      end
      if (resp_err_s) begin
        err_addr_r <= err_src_s;
      end
`ifdef BUS_FABRIC_ERR_IRQ_EN
      err_irq_r   <= err_irq_nxt_s;
`endif
    end
  end

  assign bus.s_sel   = s_sel_r;
  assign bus.m_ready = m_ready_r;
  assign bus.m_rdata = m_rdata_r;
  assign bus.s_addr  = s_addr_r;
  assign bus.s_wdata = s_wdata_r;
  assign bus.s_wstrb = s_wstrb_r;
  assign bus_err     = bus_err_r;
  assign err_addr    = err_addr_r;
  assign err_count   = err_count_r;
`ifdef BUS_FABRIC_ERR_IRQ_EN
  assign err_irq     = err_irq_r;
`endif

endmodule

// File: tb/tb_bus_fabric.sv
// Randomized bench for bus_fabric: transaction-level model predicts select windows,
// response timing, read data and error bookkeeping; a negedge process compares every cycle.
module tb_bus_fabric;

  localparam int          TIMEOUT = 16;
  localparam logic [31:0] ERR     = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_err;
  logic [31:0] err_addr;
  logic [7:0]  err_count;
`ifdef BUS_FABRIC_ERR_IRQ_EN
  logic        err_irq;
  logic        err_irq_clr = 1'b0;
`endif

  bus_fabric_if #(.N_SLAVES(4)) bus ();

  // Slot 2 overlaps slot 0 for the low 256 bytes.
  bus_fabric #(
    .N_SLAVES   (4),
    .SLAVE_BASE ({32'h8000_2000, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000}),
    .SLAVE_MASK ({32'hFFFF_F800, 32'hFFFF_FF00, 32'hFFFF_FFFC, 32'hFFFF_C000}),
    .TIMEOUT    (TIMEOUT),
    .ERR_RDATA  (ERR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .bus_err   (bus_err),
    .err_addr  (err_addr),
`ifdef BUS_FABRIC_ERR_IRQ_EN
    .err_irq     (err_irq),
    .err_irq_clr (err_irq_clr),
`endif
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  logic [31:0] mbase [4] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 32'h8000_2000};
  logic [31:0] mmask [4] = '{32'hFFFF_C000, 32'hFFFF_FFFC, 32'hFFFF_FF00, 32'hFFFF_F800};

  int          n_checks = 0;
  int          n_errors = 0;
  bit          chk_en   = 1'b0;
  logic [3:0]  exp_sel  = 4'd0;
  bit          exp_mready = 1'b0;
  bit          exp_buserr = 1'b0;
  logic [31:0] exp_rdata = 32'd0;
  logic [7:0]  exp_cnt = 8'd0;
  logic [31:0] exp_err_addr = 32'd0;
  logic [31:0] exp_addr = 32'd0, exp_wdata = 32'd0;
  logic [3:0]  exp_wstrb = 4'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_slot(input logic [31:0] a);
    int s;
    s = -1;
    for (int i = 3; i >= 0; i--) begin
      if ((a & mmask[i]) == mbase[i]) s = i;
    end
    return s;
  endfunction

  task automatic drive_slaves(input int slot, input bit own, input bit own_rdy, input logic [31:0] rdval);
    logic [1:0] si;
    bus.s_ready = 4'($urandom);
    bus.s_rdata = {$urandom, $urandom, $urandom, $urandom};
    if (own) begin
      si = slot[1:0];
      bus.s_ready[si] = own_rdy;
      if (own_rdy) bus.s_rdata[{si, 5'b00000} +: 32] = rdval;
    end
  endtask

  // One master transaction; cycle k=0 is the first cycle m_valid is high.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                         input int delay, input logic [31:0] rdval,
                         output int slot, output int lat, output int selc);
    bit err, own, own_rdy;
    int gap;
    slot = model_slot(addr);
    err  = (slot < 0) || (delay >= TIMEOUT);
    selc = (slot < 0) ? 0 : (err ? TIMEOUT : delay + 1);
    lat  = selc + 2;
    gap  = 1 + int'($urandom_range(0, 2));
    exp_addr = addr; exp_wdata = wdata; exp_wstrb = wstrb;
    for (int k = 0; k < lat + gap; k++) begin
      bus.m_valid = (k < lat);
      bus.m_addr  = addr;
      bus.m_wdata = wdata;
      bus.m_wstrb = wstrb;
      own     = (slot >= 0) && (k >= 1) && (k <= selc);
      own_rdy = own && (k == delay + 1);
      drive_slaves(slot, own, own_rdy, rdval);
      exp_sel    = own ? (4'b0001 << slot) : 4'd0;
      exp_mready = (k == lat - 1);
      exp_buserr = exp_mready && err;
      if (exp_mready) begin
        exp_rdata = err ? ERR : rdval;
        if (err) begin
          exp_err_addr = addr;
          if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  // Per-cycle comparison against the model's expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      check("s_sel", 32'(bus.s_sel), 32'(exp_sel));
      check("m_ready", 32'(bus.m_ready), 32'(exp_mready));
      check("bus_err", 32'(bus_err), 32'(exp_buserr));
      check("err_count", 32'(err_count), 32'(exp_cnt));
      check("err_addr", err_addr, exp_err_addr);
      if (exp_mready) check("m_rdata", bus.m_rdata, exp_rdata);
      if (exp_sel != 4'd0) begin
        check("s_addr", bus.s_addr, exp_addr);
        check("s_wdata", bus.s_wdata, exp_wdata);
        check("s_wstrb", 32'(bus.s_wstrb), 32'(exp_wstrb));
      end
    end
  end

  initial begin
    int slot, lat, selc, kind, pick, dly;
    logic [31:0] addr;
    reset = 1'b1;
    bus.m_valid = 1'b0; bus.m_addr = 32'd0; bus.m_wdata = 32'd0; bus.m_wstrb = 4'd0;
    bus.s_ready = 4'd0; bus.s_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_sel", 32'(bus.s_sel), 32'd0);
    check("rst_m_ready", 32'(bus.m_ready), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_m_rdata", bus.m_rdata, 32'd0);
    check("rst_s_addr", bus.s_addr, 32'd0);
    check("rst_s_wdata", bus.s_wdata, 32'd0);
    check("rst_s_wstrb", 32'(bus.s_wstrb), 32'd0);
    check("rst_err_addr", err_addr, 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    reset  = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // Overlapped read: slot 0 wins, ready on first select cycle.
    run_txn(32'h0000_0010, 32'd0, 4'd0, 0, 32'h1234_5678, slot, lat, selc);
    check("pin_overlap_slot", 32'(slot), 32'd0);
    check("pin_read_lat", 32'(lat), 32'd3);
    check("dut_read_rdata", bus.m_rdata, 32'h1234_5678);

    // Write with slave1 ready after 5 cycles.
    run_txn(32'h8000_0000, 32'h0000_003F, 4'b0001, 5, 32'h0, slot, lat, selc);
    check("pin_write_selc", 32'(selc), 32'd6);
    check("dut_write_errcnt", 32'(err_count), 32'd0);

    // Unmapped read.
    run_txn(32'h4000_0000, 32'd0, 4'd0, 0, 32'h0, slot, lat, selc);
    check("pin_unmapped_lat", 32'(lat), 32'd2);
    check("dut_unmapped_rdata", bus.m_rdata, 32'hDEAD_BEEF);
    check("dut_unmapped_erraddr", err_addr, 32'h4000_0000);
    check("dut_unmapped_errcnt", 32'(err_count), 32'd1);

    // Slave3 never ready: timeout.
    run_txn(32'h8000_2004, 32'd0, 4'd0, 1000, 32'h0, slot, lat, selc);
    check("pin_timeout_selc", 32'(selc), 32'd16);
    check("dut_timeout_rdata", bus.m_rdata, 32'hDEAD_BEEF);
    check("dut_timeout_errcnt", 32'(err_count), 32'd2);

    // Ready in the very cycle the timeout would fire.
    run_txn(32'h8000_2010, 32'd0, 4'd0, TIMEOUT - 1, 32'h5A5A_0F0F, slot, lat, selc);
    check("dut_edge_rdata", bus.m_rdata, 32'h5A5A_0F0F);

    // 300 unmapped accesses saturate the counter.
    for (int i = 0; i < 300; i++) begin
      run_txn(32'h4000_0000 | ($urandom & 32'h0000_FFFF), $urandom, 4'd0, 0, 32'h0, slot, lat, selc);
    end
    check("dut_errcnt_sat", 32'(err_count), 32'd255);

    // Reset pulsed mid-ACTIVE.
    bus.m_valid = 1'b1; bus.m_addr = 32'h8000_2004; bus.m_wstrb = 4'd0;
    exp_addr = 32'h8000_2004; exp_wdata = bus.m_wdata; exp_wstrb = 4'd0;
    for (int k = 0; k < 4; k++) begin
      drive_slaves(3, k >= 1, 1'b0, 32'd0);
      exp_sel = (k >= 1) ? 4'b1000 : 4'd0;
      exp_mready = 1'b0; exp_buserr = 1'b0;
      @(posedge clk); #1;
    end
    chk_en = 1'b0; reset = 1'b1; bus.m_valid = 1'b0;
    @(posedge clk); #1;
    check("midrst_s_sel", 32'(bus.s_sel), 32'd0);
    check("midrst_m_ready", 32'(bus.m_ready), 32'd0);
    check("midrst_errcnt", 32'(err_count), 32'd0);
    check("midrst_m_rdata", bus.m_rdata, 32'd0);
    reset = 1'b0;
    exp_cnt = 8'd0; exp_err_addr = 32'd0; exp_sel = 4'd0; exp_mready = 1'b0; exp_buserr = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;
    run_txn(32'h0000_0020, 32'd0, 4'd0, 2, 32'hCAFE_0001, slot, lat, selc);
    check("dut_post_reset_rdata", bus.m_rdata, 32'hCAFE_0001);

    // Randomized traffic.
    for (int i = 0; i < 250; i++) begin
      kind = int'($urandom_range(0, 4));
      case (kind)
        0:       addr = $urandom & 32'h0000_3FFF;
        1:       addr = 32'h8000_0000 | ($urandom & 32'h0000_0003);
        2:       addr = 32'h8000_2000 | ($urandom & 32'h0000_07FF);
        3:       addr = $urandom;
        default: addr = 32'h8000_0004;
      endcase
      pick = int'($urandom_range(0, 9));
      dly  = (pick < 7) ? int'($urandom_range(0, 4)) : int'($urandom_range(13, 19));
      run_txn(addr, $urandom, 4'($urandom), dly, $urandom, slot, lat, selc);
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
